// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Byte-stream-to-serial UART transmitter, 8N1 framing (or 8N2), LSB first.
// Bytes are queued in a small input FIFO. A frame engine pops them one at a
// time and shifts them out on a registered serial line. When the FIFO still
// holds data at the end of a stop period, the next start bit follows on the
// very next edge, so there is no idle gap between frames.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//   FIFO_DEPTH   : input FIFO entries (power of two, >= 2)
//   STOP_BITS    : number of stop bits (1 or 2)
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data holds a byte to send
//   in_data    in   [7:0] byte to transmit, sampled only on the accepting edge
//   in_ready   out  FIFO can accept a byte this cycle (registered count only)
//   tx         out  serial line, idle high, registered
//   busy       out  frame in progress or FIFO non-empty
//   fifo_count out  bytes queued, excluding the frame in flight
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [PTR_W:0]   FULL_COUNT  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [2:0]       LAST_DATA   = 3'd7;
   localparam logic [2:0]       LAST_STOP   = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t               r_state;
   logic [CNT_W-1:0]     r_baud;
   logic [2:0]           r_bit_idx;     // data bit index in DATA, stop bit index in STOP
   logic [7:0]           r_shift;
   logic                 r_tx;

   logic [7:0]           r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [PTR_W:0]       r_count;

   // ---------------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------------
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     w_baud_nxt;
   logic [2:0]           w_bit_idx_nxt;
   logic [7:0]           w_shift_nxt;
   logic                 w_tx_nxt;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_in_ready;
   logic                 w_fifo_empty;
   logic                 w_baud_zero;
   logic [CNT_W-1:0]     w_baud_dec;
   logic [7:0]           w_head;

   // Ready depends only on the registered count: a push is refused when full
   // even if the frame engine pops in the same cycle.
   assign w_in_ready   = (r_count != FULL_COUNT);
   assign w_push       = in_valid && w_in_ready;
   assign w_fifo_empty = (r_count == '0);
   assign w_head       = r_mem[r_rd_ptr];
   assign w_baud_zero  = (r_baud == '0);
   assign w_baud_dec   = r_baud - CNT_W'(1);

   // ---------------------------------------------------------------------------
   // Input FIFO
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         // Simultaneous push and pop leaves the count unchanged.
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
            2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Frame engine: next-state and datapath updates
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = r_baud;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_pop         = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop         = 1'b1;
               w_shift_nxt   = w_head;
               w_baud_nxt    = BAUD_RELOAD;
               w_bit_idx_nxt = '0;
               w_state_nxt   = S_START;
            end
         end

         S_START: begin
            if (w_baud_zero) begin
               w_baud_nxt  = BAUD_RELOAD;
               w_state_nxt = S_DATA;
            end else begin
               w_baud_nxt  = w_baud_dec;
            end
         end

         S_DATA: begin
            if (w_baud_zero) begin
               w_baud_nxt = BAUD_RELOAD;
               if (r_bit_idx == LAST_DATA) begin
                  w_bit_idx_nxt = '0;
                  w_state_nxt   = S_STOP;
               end else begin
                  w_shift_nxt   = {1'b0, r_shift[7:1]};
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end else begin
               w_baud_nxt = w_baud_dec;
            end
         end

         S_STOP: begin
            if (w_baud_zero) begin
               if (r_bit_idx == LAST_STOP) begin
                  // End of frame: chain straight into the next start bit when
                  // data is waiting, otherwise fall back to idle.
                  if (!w_fifo_empty) begin
                     w_pop         = 1'b1;
                     w_shift_nxt   = w_head;
                     w_baud_nxt    = BAUD_RELOAD;
                     w_bit_idx_nxt = '0;
                     w_state_nxt   = S_START;
                  end else begin
                     w_state_nxt   = S_IDLE;
                  end
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
                  w_baud_nxt    = BAUD_RELOAD;
               end
            end else begin
               w_baud_nxt = w_baud_dec;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // The line level is derived from the next state so that tx is a plain
   // register output that changes on the same edge as the state.
   always_comb begin
      w_tx_nxt = 1'b1;
      case (w_state_nxt)
         S_IDLE:  w_tx_nxt = 1'b1;
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_shift_nxt[0];
         S_STOP:  w_tx_nxt = 1'b1;
         default: w_tx_nxt = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Frame engine: state registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_baud    <= w_baud_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_tx      <= w_tx_nxt;
      end
   end

   // Shift register carries only data; it is always reloaded before use.
   always_ff @(posedge clk) begin
      r_shift <= w_shift_nxt;
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign in_ready   = w_in_ready;
   assign tx         = r_tx;
   assign busy       = (r_state != S_IDLE) || !w_fifo_empty;
   assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed bench for uart_tx_serializer. Instance A (4 clocks/bit, depth 4,
// one stop bit) covers reset, single frame, burst/full, stall stability and
// reset mid-frame. Instance B (5 clocks/bit, two stop bits) is decoded by a
// mid-bit sampler for all 256 byte values.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;

   logic       a_valid;
   logic [7:0] a_data;
   logic       a_ready, a_tx, a_busy;
   logic [2:0] a_count;

   logic       b_valid;
   logic [7:0] b_data;
   logic       b_ready, b_tx, b_busy;
   logic [2:0] b_count;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_serializer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1)) u_dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (a_valid),
      .in_data    (a_data),
      .in_ready   (a_ready),
      .tx         (a_tx),
      .busy       (a_busy),
      .fifo_count (a_count)
   );

   uart_tx_serializer #(.CLKS_PER_BIT(5), .FIFO_DEPTH(4), .STOP_BITS(2)) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (b_valid),
      .in_data    (b_data),
      .in_ready   (b_ready),
      .tx         (b_tx),
      .busy       (b_busy),
      .fifo_count (b_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // From one falling edge, let one rising edge happen and stop at the next
   // falling edge, where outputs are stable.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Expected line level for instance A, c = cycles after the pop edge (1..40).
   function automatic logic exp_a_bit(input int c, input logic [7:0] b);
      int rel;
      rel = c - 1;
      if (rel < 4)  return 1'b0;
      if (rel < 36) return b[(rel - 4) / 4];
      return 1'b1;
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] burst [6];
      int         acc_edge [6];
      int         exp_edge [6];
      int         idx;
      int         lows;
      int         f;
      logic       rdy;

      burst    = '{8'h00, 8'hFF, 8'h55, 8'h81, 8'h3C, 8'h7E};
      exp_edge = '{0, 1, 2, 3, 4, 42};

      rst_n   = 1'b0;
      a_valid = 1'b0;
      a_data  = 8'h00;
      b_valid = 1'b0;
      b_data  = 8'h00;
      @(negedge clk);

      // ---------------- reset held for 10 cycles ----------------
      for (int i = 0; i < 10; i++) begin
         tick();
         check("rst_hold_state", {a_tx, a_ready, a_busy, a_count}, 6'b110_000);
      end
      rst_n = 1'b1;
      lows  = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (a_tx !== 1'b1 || a_busy !== 1'b0) lows++;
      end
      check("rst_release_quiet", lows, 0);
      check("rst_release_state", {a_tx, a_ready, a_busy, a_count}, 6'b110_000);

      // ---------------- single byte 0xA5 ----------------
      a_valid = 1'b1;
      a_data  = 8'hA5;
      tick();                                  // edge 0
      a_valid = 1'b0;
      a_data  = 8'h3C;                         // must not affect the frame
      check("single_cnt_e0", a_count, 1);
      check("single_tx_e0", a_tx, 1);
      for (int c = 1; c <= 44; c++) begin
         tick();
         check($sformatf("single_tx_c%0d", c), a_tx, (c <= 40) ? exp_a_bit(c, 8'hA5) : 1'b1);
         if (c == 1)  check("single_cnt_e1", a_count, 0);
         if (c == 40) check("single_busy_c40", a_busy, 1);
         if (c == 41) check("single_busy_c41", a_busy, 0);
      end

      // ---------------- burst / full / stall stability ----------------
      idx = 0;
      for (int c = 0; c <= 241; c++) begin
         rdy = a_ready;
         if (idx < 6) begin
            a_valid = 1'b1;
            a_data  = rdy ? burst[idx] : 8'($urandom);
         end else begin
            a_valid = 1'b0;
            a_data  = 8'($urandom);
         end
         tick();                               // edge c
         if (idx < 6 && rdy) begin
            acc_edge[idx] = c;
            idx++;
         end
         if (c == 4) begin
            check("burst_ready_e4", a_ready, 0);
            check("burst_cnt_e4", a_count, 4);
         end
         if (c >= 1 && c <= 240) begin
            f = (c - 1) / 40;
            check($sformatf("burst_tx_c%0d", c), a_tx, exp_a_bit(c - 40 * f, burst[f]));
         end
         if (c == 241) begin
            check("burst_busy_end", a_busy, 0);
            check("burst_tx_end", a_tx, 1);
         end
      end
      check("burst_accepted", idx, 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("burst_acc_edge%0d", i), (i < idx) ? acc_edge[i] : -1, exp_edge[i]);
      end

      // ---------------- reset mid-frame ----------------
      a_valid = 1'b1;
      a_data  = 8'h0F;
      tick();                                  // edge 0
      a_data  = 8'h33;
      tick();                                  // edge 1: pop 0x0F, push 0x33
      a_data  = 8'h44;
      tick();                                  // edge 2
      a_valid = 1'b0;
      for (int c = 3; c <= 18; c++) tick();    // now inside data bit 3
      check("midrst_cnt_pre", a_count, 2);
      check("midrst_busy_pre", a_busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_state_async", {a_tx, a_ready, a_busy, a_count}, 6'b110_000);
      @(negedge clk);
      repeat (3) tick();
      rst_n = 1'b1;
      lows  = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (a_tx !== 1'b1 || a_busy !== 1'b0) lows++;
      end
      check("midrst_quiet", lows, 0);
      check("midrst_cnt_post", a_count, 0);

      // ---------------- exhaustive loopback on instance B ----------------
      fork
         begin : lb_driver
            int  guard;
            int  gap;
            logic acc;
            logic r;
            for (int b = 0; b < 256; b++) begin
               gap = $urandom_range(0, 3);
               b_valid = 1'b0;
               repeat (gap) tick();
               b_valid = 1'b1;
               b_data  = 8'(b);
               acc     = 1'b0;
               guard   = 0;
               while (!acc && guard < 2000) begin
                  r = b_ready;
                  tick();
                  acc = r;
                  guard++;
               end
               if (!acc) begin
                  check("lb_bytes_pushed", b, 256);
                  break;
               end
            end
            b_valid = 1'b0;
         end
         begin : lb_sampler
            int         g;
            logic [7:0] rx;
            for (int n = 0; n < 256; n++) begin
               g = 0;
               while (b_tx !== 1'b0 && g < 5000) begin
                  @(negedge clk);
                  g++;
               end
               if (b_tx !== 1'b0) begin
                  check("lb_bytes_decoded", n, 256);
                  break;
               end
               repeat (2) @(negedge clk);      // middle of start bit
               check("lb_start", b_tx, 0);
               for (int k = 0; k < 8; k++) begin
                  repeat (5) @(negedge clk);
                  rx[k] = b_tx;
               end
               check($sformatf("lb_data_%0d", n), rx, n);
               repeat (5) @(negedge clk);
               check("lb_stop1", b_tx, 1);
               repeat (5) @(negedge clk);
               check("lb_stop2", b_tx, 1);
            end
         end
      join
      repeat (5) tick();
      check("lb_busy_end", b_busy, 0);
      check("lb_cnt_end", b_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
